// File: rtl/exu_csr_ctrl.sv
// exu_csr_ctrl: CSR-instruction controller placed directly in front of the CSR
// register file. It accepts one decoded CSR op, issues a single-cycle access
// to the CSR file, and returns the old CSR value to writeback through a
// valid/ready output buffer.
module exu_csr_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  // op request
  input  logic            csr_i_valid,
  output logic            csr_i_ready,
  input  logic [2:0]      csr_i_funct3,
  input  logic [11:0]     csr_i_idx,
  input  logic [XLEN-1:0] csr_i_rs1,
  input  logic [4:0]      csr_i_zimm,
  input  logic            csr_i_rs1x0,
  input  logic [4:0]      csr_i_rdidx,
  // CSR file access
  output logic            csr_ena,
  output logic            csr_rd_en,
  output logic            csr_wr_en,
  output logic [11:0]     csr_idx,
  output logic [XLEN-1:0] wbck_csr_dat,
  input  logic [XLEN-1:0] read_csr_dat,
  input  logic            csr_access_ilgl,
  // result to writeback
  output logic            csr_o_valid,
  input  logic            csr_o_ready,
  output logic [XLEN-1:0] csr_o_wdat,
  output logic [4:0]      csr_o_rdidx,
  output logic            csr_o_rdwen,
  output logic            csr_o_ilgl
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // funct3[1:0] selects the operation; funct3[2] selects the immediate form.
  localparam logic [1:0] OP_RW = 2'b01;
  localparam logic [1:0] OP_RS = 2'b10;
  localparam logic [1:0] OP_RC = 2'b11;

  state_e state_q, state_d;

  // Captured op
  logic [2:0]      funct3_q;
  logic [11:0]     idx_q;
  logic [XLEN-1:0] opnd_q;
  logic            nz_q;
  logic [4:0]      rdidx_q;

  // Captured result
  logic [XLEN-1:0] wdat_q;
  logic            rdwen_q;
  logic            ilgl_q;

  logic            accept;
  logic            op_legal;
  logic            op_is_rw;
  logic [XLEN-1:0] opnd_in;
  logic            nz_in;

  assign accept   = (state_q == ST_IDLE) && csr_i_valid;
  assign op_legal = (funct3_q[1:0] != 2'b00);
  assign op_is_rw = (funct3_q[1:0] == OP_RW);

  // Immediate forms zero-extend zimm; a zero source means set/clear must not write.
  assign opnd_in = csr_i_funct3[2] ? {{(XLEN-5){1'b0}}, csr_i_zimm} : csr_i_rs1;
  assign nz_in   = csr_i_funct3[2] ? (csr_i_zimm != 5'd0) : ~csr_i_rs1x0;

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and CSR-file strobes; strobes are live only in EXEC.
  // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d      = state_q;
    csr_i_ready  = 1'b0;
    csr_ena      = 1'b0;
    csr_rd_en    = 1'b0;
    csr_wr_en    = 1'b0;
    csr_idx      = 12'd0;
    wbck_csr_dat = '0;
    unique case (state_q)
      ST_IDLE: begin
        csr_i_ready = 1'b1;
        if (csr_i_valid) state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (op_legal) begin
          csr_ena   = 1'b1;
          csr_idx   = idx_q;
          csr_rd_en = op_is_rw ? (rdidx_q != 5'd0) : 1'b1;
          csr_wr_en = op_is_rw ? 1'b1 : nz_q;
          case (funct3_q[1:0])
            OP_RW:   wbck_csr_dat = opnd_q;
            OP_RS:   wbck_csr_dat = read_csr_dat | opnd_q;
            OP_RC:   wbck_csr_dat = read_csr_dat & ~opnd_q;
            default: wbck_csr_dat = '0;
          endcase
        end
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (csr_o_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Op capture on acceptance; held until the next op is accepted.
  // NOTE: capture registers are reset so outputs are defined before the first op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      funct3_q <= 3'd0;
      idx_q    <= 12'd0;
      opnd_q   <= '0;
      nz_q     <= 1'b0;
      rdidx_q  <= 5'd0;
    end else if (accept) begin
      funct3_q <= csr_i_funct3;
      idx_q    <= csr_i_idx;
      opnd_q   <= opnd_in;
      nz_q     <= nz_in;
      rdidx_q  <= csr_i_rdidx;
    end
  end

  // Result capture in EXEC; stays stable through RESP regardless of backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdat_q  <= '0;
      rdwen_q <= 1'b0;
      ilgl_q  <= 1'b0;
    end else if (state_q == ST_EXEC) begin
      if (!op_legal || csr_access_ilgl) begin
        wdat_q  <= '0;
        rdwen_q <= 1'b0;
        ilgl_q  <= 1'b1;
      end else begin
        wdat_q  <= csr_rd_en ? read_csr_dat : '0;
        rdwen_q <= (rdidx_q != 5'd0);
        ilgl_q  <= 1'b0;
      end
    end
  end

  assign csr_o_valid = (state_q == ST_RESP);
  assign csr_o_wdat  = wdat_q;
  assign csr_o_rdidx = rdidx_q;
  assign csr_o_rdwen = rdwen_q;
  assign csr_o_ilgl  = ilgl_q;

endmodule

// File: tb/tb_exu_csr_ctrl.sv
// Directed testbench for exu_csr_ctrl with hand-computed expected values.
module tb_exu_csr_ctrl;

  localparam int XLEN = 32;

  logic            clk;
  logic            rst_n;
  logic            csr_i_valid;
  logic            csr_i_ready;
  logic [2:0]      csr_i_funct3;
  logic [11:0]     csr_i_idx;
  logic [XLEN-1:0] csr_i_rs1;
  logic [4:0]      csr_i_zimm;
  logic            csr_i_rs1x0;
  logic [4:0]      csr_i_rdidx;
  logic            csr_ena;
  logic            csr_rd_en;
  logic            csr_wr_en;
  logic [11:0]     csr_idx;
  logic [XLEN-1:0] wbck_csr_dat;
  logic [XLEN-1:0] read_csr_dat;
  logic            csr_access_ilgl;
  logic            csr_o_valid;
  logic            csr_o_ready;
  logic [XLEN-1:0] csr_o_wdat;
  logic [4:0]      csr_o_rdidx;
  logic            csr_o_rdwen;
  logic            csr_o_ilgl;

  int vectors;
  int miscompares;

  exu_csr_ctrl #(.XLEN(XLEN)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .csr_i_valid     (csr_i_valid),
    .csr_i_ready     (csr_i_ready),
    .csr_i_funct3    (csr_i_funct3),
    .csr_i_idx       (csr_i_idx),
    .csr_i_rs1       (csr_i_rs1),
    .csr_i_zimm      (csr_i_zimm),
    .csr_i_rs1x0     (csr_i_rs1x0),
    .csr_i_rdidx     (csr_i_rdidx),
    .csr_ena         (csr_ena),
    .csr_rd_en       (csr_rd_en),
    .csr_wr_en       (csr_wr_en),
    .csr_idx         (csr_idx),
    .wbck_csr_dat    (wbck_csr_dat),
    .read_csr_dat    (read_csr_dat),
    .csr_access_ilgl (csr_access_ilgl),
    .csr_o_valid     (csr_o_valid),
    .csr_o_ready     (csr_o_ready),
    .csr_o_wdat      (csr_o_wdat),
    .csr_o_rdidx     (csr_o_rdidx),
    .csr_o_rdwen     (csr_o_rdwen),
    .csr_o_ilgl      (csr_o_ilgl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full op: accept, check EXEC strobes, check held result, release.
  // After acceptance the request inputs are scrambled so only registered
  // values can produce the expected strobes and result.
  task automatic do_op(input string tag, input logic [2:0] f3, input logic [11:0] idx,
                       input logic [31:0] rs1, input logic [4:0] zimm, input logic rs1x0,
                       input logic [4:0] rd, input logic [31:0] rdata, input logic ailgl,
                       input logic e_ena, input logic e_rd, input logic e_wr,
                       input logic chk_wbck, input logic [31:0] e_wbck,
                       input logic [31:0] e_wdat, input logic e_rdwen, input logic e_ilgl);
    csr_o_ready  = 1'b0;
    csr_i_valid  = 1'b1;
    csr_i_funct3 = f3;
    csr_i_idx    = idx;
    csr_i_rs1    = rs1;
    csr_i_zimm   = zimm;
    csr_i_rs1x0  = rs1x0;
    csr_i_rdidx  = rd;
    chk({tag, ".i_ready"}, csr_i_ready, 1);
    tick();
    csr_i_valid     = 1'b0;
    csr_i_funct3    = 3'b000;
    csr_i_idx       = ~idx;
    csr_i_rs1       = ~rs1;
    csr_i_zimm      = ~zimm;
    csr_i_rs1x0     = ~rs1x0;
    csr_i_rdidx     = ~rd;
    read_csr_dat    = rdata;
    csr_access_ilgl = ailgl;
    #1;
    chk({tag, ".ena"}, csr_ena, e_ena);
    chk({tag, ".rd_en"}, csr_rd_en, e_rd);
    chk({tag, ".wr_en"}, csr_wr_en, e_wr);
    if (e_ena) chk({tag, ".idx"}, csr_idx, idx);
    if (chk_wbck) chk({tag, ".wbck"}, wbck_csr_dat, e_wbck);
    chk({tag, ".exec_o_valid"}, csr_o_valid, 0);
    chk({tag, ".exec_i_ready"}, csr_i_ready, 0);
    tick();
    read_csr_dat    = ~rdata;
    csr_access_ilgl = 1'b0;
    #1;
    chk({tag, ".o_valid"}, csr_o_valid, 1);
    chk({tag, ".wdat"}, csr_o_wdat, e_wdat);
    chk({tag, ".rdidx"}, csr_o_rdidx, rd);
    chk({tag, ".rdwen"}, csr_o_rdwen, e_rdwen);
    chk({tag, ".ilgl"}, csr_o_ilgl, e_ilgl);
    chk({tag, ".resp_ena"}, csr_ena, 0);
    chk({tag, ".resp_wbck"}, wbck_csr_dat, 0);
    csr_o_ready = 1'b1;
    tick();
    chk({tag, ".idle_o_valid"}, csr_o_valid, 0);
    chk({tag, ".idle_i_ready"}, csr_i_ready, 1);
    csr_o_ready = 1'b0;
  endtask

  initial begin
    vectors         = 0;
    miscompares     = 0;
    rst_n           = 1'b0;
    csr_i_valid     = 1'b0;
    csr_i_funct3    = 3'b000;
    csr_i_idx       = 12'd0;
    csr_i_rs1       = 32'd0;
    csr_i_zimm      = 5'd0;
    csr_i_rs1x0     = 1'b0;
    csr_i_rdidx     = 5'd0;
    read_csr_dat    = 32'd0;
    csr_access_ilgl = 1'b0;
    csr_o_ready     = 1'b0;

    // Reset held for 3 cycles
    repeat (3) tick();
    chk("rst.i_ready", csr_i_ready, 1);
    chk("rst.ena", csr_ena, 0);
    chk("rst.rd_en", csr_rd_en, 0);
    chk("rst.wr_en", csr_wr_en, 0);
    chk("rst.idx", csr_idx, 0);
    chk("rst.wbck", wbck_csr_dat, 0);
    chk("rst.o_valid", csr_o_valid, 0);
    chk("rst.wdat", csr_o_wdat, 0);
    chk("rst.rdidx", csr_o_rdidx, 0);
    chk("rst.rdwen", csr_o_rdwen, 0);
    chk("rst.ilgl", csr_o_ilgl, 0);
    rst_n = 1'b1;
    tick();
    chk("idle.ena", csr_ena, 0);
    chk("idle.o_valid", csr_o_valid, 0);

    //      tag        f3      idx      rs1           zimm   x0    rd     rdata         ailgl ena rd wr  cw wbck          wdat          rdwen ilgl
    do_op("rw",       3'b001, 12'h300, 32'h0000_0088, 5'd0,  1'b0, 5'd5,  32'h0000_1800, 1'b0, 1, 1, 1, 1, 32'h0000_0088, 32'h0000_1800, 1, 0);
    do_op("rs_x0",    3'b010, 12'h341, 32'h0000_0000, 5'd0,  1'b1, 5'd7,  32'h0000_ABCD, 1'b0, 1, 1, 0, 1, 32'h0000_ABCD, 32'h0000_ABCD, 1, 0);
    do_op("rci",      3'b111, 12'h344, 32'hFFFF_FFFF, 5'd3,  1'b0, 5'd2,  32'h0000_000F, 1'b0, 1, 1, 1, 1, 32'h0000_000C, 32'h0000_000F, 1, 0);
    do_op("rw_rd0",   3'b001, 12'h305, 32'h0000_1234, 5'd0,  1'b0, 5'd0,  32'h0000_DEAD, 1'b0, 1, 0, 1, 1, 32'h0000_1234, 32'h0000_0000, 0, 0);
    do_op("rs_ailgl", 3'b010, 12'hC00, 32'h0000_00F0, 5'd0,  1'b0, 5'd3,  32'h0000_000F, 1'b1, 1, 1, 1, 1, 32'h0000_00FF, 32'h0000_0000, 0, 1);
    do_op("f3_100",   3'b100, 12'h300, 32'h0000_0001, 5'd1,  1'b0, 5'd9,  32'h1111_1111, 1'b0, 0, 0, 0, 0, 32'h0000_0000, 32'h0000_0000, 0, 1);
    do_op("f3_000",   3'b000, 12'h300, 32'h0000_0001, 5'd1,  1'b0, 5'd4,  32'h2222_2222, 1'b0, 0, 0, 0, 0, 32'h0000_0000, 32'h0000_0000, 0, 1);
    do_op("rsi_z0",   3'b110, 12'h300, 32'hFFFF_FFFF, 5'd0,  1'b0, 5'd1,  32'h8000_0001, 1'b0, 1, 1, 0, 1, 32'h8000_0001, 32'h8000_0001, 1, 0);
    do_op("rwi_max",  3'b101, 12'hFFF, 32'hAAAA_AAAA, 5'd31, 1'b1, 5'd31, 32'h5555_5555, 1'b0, 1, 1, 1, 1, 32'h0000_001F, 32'h5555_5555, 1, 0);
    do_op("rc_wide",  3'b011, 12'h7C0, 32'hFFFF_0000, 5'd0,  1'b0, 5'd10, 32'h1234_5678, 1'b0, 1, 1, 1, 1, 32'h0000_5678, 32'h1234_5678, 1, 0);
    do_op("rs_msb",   3'b010, 12'h001, 32'h8000_0000, 5'd0,  1'b0, 5'd6,  32'h0000_0001, 1'b0, 1, 1, 1, 1, 32'h8000_0001, 32'h0000_0001, 1, 0);

    // Backpressure: result held 5 cycles while a second op waits upstream
    csr_i_valid  = 1'b1;
    csr_i_funct3 = 3'b001;
    csr_i_idx    = 12'h340;
    csr_i_rs1    = 32'hCAFE_0001;
    csr_i_rs1x0  = 1'b0;
    csr_i_rdidx  = 5'd12;
    tick();
    csr_i_rs1    = 32'h0BAD_0002;
    csr_i_rdidx  = 5'd13;
    read_csr_dat = 32'h7777_0000;
    #1;
    chk("bp.exec_wbck", wbck_csr_dat, 32'hCAFE_0001);
    tick();
    read_csr_dat = 32'h0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp.o_valid", csr_o_valid, 1);
      chk("bp.wdat", csr_o_wdat, 32'h7777_0000);
      chk("bp.rdidx", csr_o_rdidx, 12);
      chk("bp.i_ready", csr_i_ready, 0);
      chk("bp.ena", csr_ena, 0);
      tick();
    end
    csr_o_ready = 1'b1;
    tick();
    csr_o_ready = 1'b0;
    chk("bp.release_o_valid", csr_o_valid, 0);
    chk("bp.release_i_ready", csr_i_ready, 1);
    tick();
    csr_i_valid  = 1'b0;
    read_csr_dat = 32'h0000_0042;
    #1;
    chk("bp.next_ena", csr_ena, 1);
    chk("bp.next_wbck", wbck_csr_dat, 32'h0BAD_0002);
    tick();
    #1;
    chk("bp.next_wdat", csr_o_wdat, 32'h0000_0042);
    chk("bp.next_rdidx", csr_o_rdidx, 13);
    csr_o_ready = 1'b1;
    tick();
    csr_o_ready = 1'b0;

    // Asynchronous reset while in RESP
    csr_i_valid  = 1'b1;
    csr_i_funct3 = 3'b010;
    csr_i_rs1    = 32'h0000_00F0;
    csr_i_rdidx  = 5'd8;
    tick();
    csr_i_valid  = 1'b0;
    read_csr_dat = 32'h0000_0F00;
    tick();
    #1;
    chk("rresp.o_valid_before", csr_o_valid, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rresp.o_valid", csr_o_valid, 0);
    chk("rresp.wdat", csr_o_wdat, 0);
    chk("rresp.rdidx", csr_o_rdidx, 0);
    chk("rresp.i_ready", csr_i_ready, 1);
    tick();
    rst_n = 1'b1;
    tick();
    chk("rresp.post_ena", csr_ena, 0);
    chk("rresp.post_o_valid", csr_o_valid, 0);

    // Asynchronous reset while in EXEC: no strobe may follow
    csr_i_valid  = 1'b1;
    csr_i_funct3 = 3'b001;
    csr_i_rdidx  = 5'd3;
    tick();
    csr_i_valid = 1'b0;
    #1;
    chk("rexec.ena_before", csr_ena, 1);
    rst_n = 1'b0;
    #1;
    chk("rexec.ena", csr_ena, 0);
    chk("rexec.wr_en", csr_wr_en, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("rexec.post_ena", csr_ena, 0);
    tick();
    chk("rexec.post_o_valid", csr_o_valid, 0);
    chk("rexec.post_i_ready", csr_i_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/exu_csr_ctrl.md
Name: exu_csr_ctrl

Overview:
- CSR-instruction controller sitting directly upstream of the CSR register file block (exu_csr).
- Accepts one decoded CSRRW/CSRRS/CSRRC/CSRRWI/CSRRSI/CSRRCI op per handshake and drives the CSR file's csr_ena/csr_rd_en/csr_wr_en/csr_idx/wbck_csr_dat for exactly one cycle.
- Captures read_csr_dat and returns the old CSR value to integer writeback through a valid/ready output buffer.

Parameters:
- XLEN, 32, data width of rs1, CSR data and writeback data.

Ports:
- clk  input  1  core clock
- rst_n  input  1  reset; asynchronous assert, active-low
- csr_i_valid  input  1  op request valid
- csr_i_ready  output  1  controller can accept op
- csr_i_funct3  input  3  CSR funct3: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI
- csr_i_idx  input  12  CSR address
- csr_i_rs1  input  XLEN  rs1 value (register forms)
- csr_i_zimm  input  5  immediate (imm forms)
- csr_i_rs1x0  input  1  rs1 index is x0
- csr_i_rdidx  input  5  destination register index
- csr_ena  output  1  CSR access strobe to CSR file
- csr_rd_en  output  1  CSR read enable
- csr_wr_en  output  1  CSR write enable
- csr_idx  output  12  CSR address to CSR file
- wbck_csr_dat  output  XLEN  CSR write data
- read_csr_dat  input  XLEN  CSR read data, combinational from CSR file, same cycle as csr_ena
- csr_access_ilgl  input  1  CSR file flags illegal access, same cycle as csr_ena
- csr_o_valid  output  1  result valid
- csr_o_ready  input  1  writeback accepts result
- csr_o_wdat  output  XLEN  old CSR value for rd
- csr_o_rdidx  output  5  rd index
- csr_o_rdwen  output  1  rd write enable
- csr_o_ilgl  output  1  illegal-instruction flag

Behaviour:
- Async active-low reset:
  - state=IDLE; all capture regs cleared.
  - csr_i_ready=1, csr_ena=0, csr_rd_en=0, csr_wr_en=0, csr_idx=0, wbck_csr_dat=0.
  - csr_o_valid=0, csr_o_wdat=0, csr_o_rdidx=0, csr_o_rdwen=0, csr_o_ilgl=0.
- FSM states IDLE, EXEC, RESP:
  - IDLE: csr_i_ready=1. On csr_i_valid, register funct3, idx, operand, rs1x0, rdidx, then go to EXEC.
  - EXEC (1 cycle): csr_i_ready=0. Drive CSR strobes from the registered op. Capture read_csr_dat and csr_access_ilgl into the output regs. Go to RESP.
  - RESP: csr_o_valid=1, csr_i_ready=0. On csr_o_ready, go to IDLE. Outputs hold stable while csr_o_ready=0, for any number of cycles.
- Latency: op accepted at edge N; CSR strobe asserted in cycle N+1; csr_o_valid asserted from cycle N+2. Minimum 3 cycles per op. No back-to-back acceptance.
- Operand: register forms use rs1. Imm forms use zimm zero-extended to XLEN.
- Write-suppress flag "nz": register forms use ~rs1x0; imm forms use (zimm!=0).
- Enables in EXEC:
  - RW/RWI: csr_rd_en=(rdidx!=0), csr_wr_en=1.
  - RS/RC/RSI/RCI: csr_rd_en=1, csr_wr_en=nz.
  - csr_ena=1 for valid funct3. csr_idx = registered idx.
- wbck_csr_dat:
  - RW* = operand.
  - RS* = read_csr_dat | operand.
  - RC* = read_csr_dat & ~operand.
  - Full XLEN bitwise, no truncation.
  - Outside EXEC, csr_ena/csr_rd_en/csr_wr_en = 0 and wbck_csr_dat = 0.
- Invalid funct3 (000, 100):
  - EXEC drives csr_ena=0, csr_rd_en=0, csr_wr_en=0.
  - Result: csr_o_ilgl=1, csr_o_rdwen=0, csr_o_wdat=0.
- csr_access_ilgl=1 in EXEC: csr_o_ilgl=1, csr_o_rdwen=0, csr_o_wdat=0. Any write the CSR file blocks is its responsibility; this block still drives the strobe.
- Legal result: csr_o_wdat = read_csr_dat sampled in EXEC if csr_rd_en, else 0. csr_o_rdwen=(rdidx!=0). csr_o_ilgl=0.
- csr_i_valid while not in IDLE is ignored (ready=0). Upstream must hold the op.
- Reset mid-operation (EXEC or RESP) returns to IDLE with reset values; the in-flight op is discarded, no strobe issued afterwards.

Test Plan:
- Reset then idle: rst_n low for 3 cycles -> csr_i_ready=1, all strobes 0, csr_o_valid=0. Asserting rst_n low during RESP -> csr_o_valid drops immediately (async).
- CSRRW: funct3=001, idx=0x300, rs1=0x0000_0088, rdidx=5, read_csr_dat=0x1800 -> cycle N+1: csr_ena=1, rd_en=1, wr_en=1, wbck=0x88. Cycle N+2: o_valid=1, wdat=0x1800, rdidx=5, rdwen=1.
- CSRRS with rs1=x0: funct3=010, rs1x0=1, read=0xABCD -> rd_en=1, wr_en=0, wdat=0xABCD. Then CSRRCI zimm=0x3, read=0xF -> wr_en=1, wbck=0xC.
- CSRRW with rd=x0: rdidx=0 -> rd_en=0, wr_en=1, rdwen=0, wdat=0.
- Illegal: csr_access_ilgl=1 in EXEC -> o_ilgl=1, rdwen=0. funct3=100 -> csr_ena never asserted, o_ilgl=1.
- Backpressure: csr_o_ready=0 for 5 cycles -> o_valid and o_wdat held, i_ready=0, second i_valid not accepted. csr_o_ready=1 -> IDLE next cycle, next op accepted.
